btn_conditioner: RTL

Board-level input conditioner for the Boolean board top level. It synchronizes and debounces the raw push buttons and produces clean levels plus one-cycle press pulses for the embedded system's button inputs. It also generates the CPU reset `sys_resetn`, which feeds `embsys.resetn`. That reset is asserted only after the BTN0+BTN1 chord has been held for a programmable time, never on a momentary chord.

---
 rtl/btn_conditioner.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces the raw push buttons and emits
// per-button rising-edge pulses. It also drives the CPU reset sys_resetn,
// which goes low only after the BTN0+BTN1 chord has been held for CHORD_CYCLES.
// Optional feature macro: BTN_EDGE_PULSE_EN. When it is defined, the
// o_btn_rise registers are built. When it is undefined, o_btn_rise is tied to 0.
`timescale 1ns / 1ps

module btn_conditioner #(
  parameter int unsigned NUM_BTN              = 4,
  parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
  parameter int unsigned CHORD_CYCLES         = 100_000_000,
  parameter int unsigned RESET_STRETCH_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_btn_db,
  output logic [NUM_BTN-1:0] o_btn_rise,
  output logic               o_chord_active,
  output logic               o_sys_resetn
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CW = $clog2(CHORD_CYCLES);
  // A one-cycle stretch still needs a 1-bit counter.
  localparam int unsigned SW = (RESET_STRETCH_CYCLES > 1) ? $clog2(RESET_STRETCH_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHORD_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(RESET_STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StArming, StAssert, StWaitRelease} state_e;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_db;
  logic [DW-1:0]      r_cnt [NUM_BTN];
  logic [DW-1:0]      w_cnt_next [NUM_BTN];
  logic [NUM_BTN-1:0] w_db_next;
  logic               w_chord;

  state_e             r_state;
  logic [CW-1:0]      r_chord_cnt;
  logic [SW-1:0]      r_stretch_cnt;
  logic               r_chord_active;
  logic               r_sys_resetn;

  // Two-flop synchronizer for the asynchronous button pins
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce next state: count mismatch cycles, accept on the cycle the count would hit the limit
  always_comb begin
    w_db_next = r_db;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_db[i]) begin
        if (r_cnt[i] == DB_LAST) begin
          w_db_next[i] = r_sync2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_db <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_db <= w_db_next;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign o_btn_db = r_db;

`ifdef BTN_EDGE_PULSE_EN
  logic [NUM_BTN-1:0] r_rise;

  // Rise pulse lines up with the cycle the debounced level first reads 1
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rise <= '0;
    end else begin
      r_rise <= w_db_next & ~r_db;
    end
  end

  assign o_btn_rise = r_rise;
`else
  assign o_btn_rise = '0;
`endif

  assign w_chord = r_db[0] & r_db[1];

  // Chord FSM with registered chord_active and sys_resetn
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_chord_cnt    <= '0;
      r_stretch_cnt  <= '0;
      r_chord_active <= 1'b0;
      r_sys_resetn   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_sys_resetn <= 1'b1;
          r_chord_cnt  <= '0;
          if (w_chord) begin
            r_state        <= StArming;
            r_chord_active <= 1'b1;
          end
        end
        StArming: begin
          // A dropped chord bit wins over reaching the limit in the same cycle.
          if (!w_chord) begin
            r_state        <= StIdle;
            r_chord_active <= 1'b0;
          end else if (r_chord_cnt == CH_LAST) begin
            r_state        <= StAssert;
            r_chord_active <= 1'b0;
            r_sys_resetn   <= 1'b0;
            r_stretch_cnt  <= '0;
          end else begin
            r_chord_cnt <= r_chord_cnt + 1'b1;
          end
        end
        StAssert: begin
          if (r_stretch_cnt == ST_LAST) begin
            r_state      <= StWaitRelease;
            r_sys_resetn <= 1'b1;
          end else begin
            r_stretch_cnt <= r_stretch_cnt + 1'b1;
          end
        end
        StWaitRelease: begin
          r_sys_resetn <= 1'b1;
          if (!r_db[0] && !r_db[1]) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state        <= StIdle;
          r_chord_active <= 1'b0;
          r_sys_resetn   <= 1'b1;
        end
      endcase
    end
  end

  assign o_chord_active = r_chord_active;
  assign o_sys_resetn   = r_sys_resetn;

endmodule
